// File: rtl/vme_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vme_pkg
// Description : Shared types and constants for the A16/D8 VME initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package vme_pkg;

  // Bus-cycle sequencing states of the initiator
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ASTB  = 3'd2,
    ST_DSTB  = 3'd3,
    ST_REL   = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

  // A16 address modifiers accepted by the board responder
  localparam logic [5:0] AM_A16_SUP = 6'h2D;
  localparam logic [5:0] AM_A16_USR = 6'h29;

endpackage
`default_nettype wire

// File: rtl/vme_sync.sv
`default_nettype none
// ============================================================================
// Module      : vme_sync
// Description : Two-flop synchronizer for active-low asynchronous backplane
//               handshakes. Resets to 1 so a reset never looks like an
//               asserted strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module vme_sync
  import vme_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  // Next value of each stage: plain shift toward the output
  always_comb begin
    meta_d = i_async;
    sync_d = meta_q;
  end

  // Synchronizer stages, idle-high out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_sync = sync_q;

endmodule
`default_nettype wire

// File: rtl/vme_a16_master.sv
`default_nettype none
// ============================================================================
// Module      : vme_a16_master
// Description : A16/D8 VME bus initiator. Turns a single local request into
//               a full VME data-transfer cycle (setup, AS, DS, DTACK/BERR
//               wait, release) and returns read data and status.
//               Optional DTACK timeout: define VME_MASTER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vme_a16_master
  import vme_pkg::*;
#(
  parameter int         SETUP_CYC   = 2,
  parameter logic [7:0] TIMEOUT_CYC = 8'd255
) (
  input  logic        CPLDCLK,
  input  logic        CRST,
  input  logic        REQ,
  input  logic        WR,
  input  logic [15:0] ADDR,
  input  logic [5:0]  AMOD,
  input  logic [7:0]  WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [7:0]  RDATA,
  output logic [15:0] XAO,
  output logic [5:0]  XAMO,
  output logic        XASO,
  output logic [1:0]  XDSO,
  output logic        XWRITEO,
  output logic [7:0]  XDO,
  output logic        XDOE,
  input  logic [7:0]  XDI,
  input  logic        XDTACK,
  input  logic        XBERR
);

  // Last SETUP counter value before moving on to the address strobe
  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);

  logic w_dtack_s;
  logic w_berr_s;

  vme_sync u_sync_dtack (
    .clk     (CPLDCLK),
    .rst     (CRST),
    .i_async (XDTACK),
    .o_sync  (w_dtack_s)
  );

  vme_sync u_sync_berr (
    .clk     (CPLDCLK),
    .rst     (CRST),
    .i_async (XBERR),
    .o_sync  (w_berr_s)
  );

  state_t      state_q,     state_d;
  logic [3:0]  setup_cnt_q, setup_cnt_d;
  logic        busy_q,      busy_d;
  logic        done_q,      done_d;
  logic        err_q,       err_d;
  logic [7:0]  rdata_q,     rdata_d;
  logic [15:0] xao_q,       xao_d;
  logic [5:0]  xamo_q,      xamo_d;
  logic        xaso_q,      xaso_d;
  logic [1:0]  xdso_q,      xdso_d;
  logic        xwriteo_q,   xwriteo_d;
  logic [7:0]  xdo_q,       xdo_d;
  logic        xdoe_q,      xdoe_d;
`ifdef VME_MASTER_TIMEOUT_EN
  logic [7:0]  to_cnt_q,    to_cnt_d;
`else
  logic        unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  // Next-state and registered-output computation for the bus cycle
  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    rdata_d     = rdata_q;
    xao_d       = xao_q;
    xamo_d      = xamo_q;
    xaso_d      = xaso_q;
    xdso_d      = xdso_q;
    xwriteo_d   = xwriteo_q;
    xdo_d       = xdo_q;
    xdoe_d      = xdoe_q;
`ifdef VME_MASTER_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (REQ) begin
          xao_d       = ADDR;
          xamo_d      = AMOD;
          xwriteo_d   = ~WR;
          xdo_d       = WDATA;
          xdoe_d      = WR;
          busy_d      = 1'b1;
          err_d       = 1'b0;
          setup_cnt_d = 4'd0;
          state_d     = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (setup_cnt_q == SETUP_LAST) begin
          xaso_d  = 1'b0;
          state_d = ST_ASTB;
        end else begin
          setup_cnt_d = setup_cnt_q + 4'd1;
        end
      end

      ST_ASTB: begin
        xdso_d  = 2'b10;
        state_d = ST_DSTB;
`ifdef VME_MASTER_TIMEOUT_EN
        to_cnt_d = 8'd0;
`endif
      end

      ST_DSTB: begin
        // BERR has priority: a cycle flagged as error never updates RDATA
        if (!w_berr_s) begin
          err_d   = 1'b1;
          xdso_d  = 2'b11;
          xdoe_d  = 1'b0;
          state_d = ST_REL;
        end else if (!w_dtack_s) begin
          if (xwriteo_q) begin
            rdata_d = XDI;
          end
          xdso_d  = 2'b11;
          xdoe_d  = 1'b0;
          state_d = ST_REL;
        end
`ifdef VME_MASTER_TIMEOUT_EN
        else if (to_cnt_q == TIMEOUT_CYC - 8'd1) begin
          err_d   = 1'b1;
          xdso_d  = 2'b11;
          xdoe_d  = 1'b0;
          state_d = ST_REL;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
`endif
      end

      ST_REL: begin
        // Wait for the responder to withdraw both handshakes before AS rises
        if (w_dtack_s && w_berr_s) begin
          xaso_d  = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_FIN;
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, all strobes released by reset
  always_ff @(posedge CPLDCLK) begin
    if (CRST) begin
      state_q     <= ST_IDLE;
      setup_cnt_q <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 8'h00;
      xao_q       <= 16'h0000;
      xamo_q      <= 6'h00;
      xaso_q      <= 1'b1;
      xdso_q      <= 2'b11;
      xwriteo_q   <= 1'b1;
      xdo_q       <= 8'h00;
      xdoe_q      <= 1'b0;
`ifdef VME_MASTER_TIMEOUT_EN
      to_cnt_q    <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      xao_q       <= xao_d;
      xamo_q      <= xamo_d;
      xaso_q      <= xaso_d;
      xdso_q      <= xdso_d;
      xwriteo_q   <= xwriteo_d;
      xdo_q       <= xdo_d;
      xdoe_q      <= xdoe_d;
`ifdef VME_MASTER_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ERR     = err_q;
  assign RDATA   = rdata_q;
  assign XAO     = xao_q;
  assign XAMO    = xamo_q;
  assign XASO    = xaso_q;
  assign XDSO    = xdso_q;
  assign XWRITEO = xwriteo_q;
  assign XDO     = xdo_q;
  assign XDOE    = xdoe_q;

endmodule
`default_nettype wire

// File: tb/tb_vme_a16_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_vme_a16_master
// Description : Self-checking bench for vme_a16_master with a behavioural
//               VME responder and a queue of expected completion results.
//               Define VME_MASTER_TIMEOUT_EN to exercise the timeout build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vme_a16_master;
  import vme_pkg::*;

  localparam int SETUP_CYC = 2;
`ifdef VME_MASTER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CYC = 8'd20;
`else
  localparam logic [7:0] TIMEOUT_CYC = 8'd255;
`endif

  logic        CPLDCLK, CRST, REQ, WR;
  logic [15:0] ADDR;
  logic [5:0]  AMOD;
  logic [7:0]  WDATA;
  logic        BUSY, DONE, ERR;
  logic [7:0]  RDATA;
  logic [15:0] XAO;
  logic [5:0]  XAMO;
  logic        XASO;
  logic [1:0]  XDSO;
  logic        XWRITEO;
  logic [7:0]  XDO;
  logic        XDOE;
  logic [7:0]  XDI;
  logic        XDTACK, XBERR;

  vme_a16_master #(.SETUP_CYC(SETUP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .CPLDCLK(CPLDCLK), .CRST(CRST), .REQ(REQ), .WR(WR), .ADDR(ADDR),
    .AMOD(AMOD), .WDATA(WDATA), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .RDATA(RDATA), .XAO(XAO), .XAMO(XAMO), .XASO(XASO), .XDSO(XDSO),
    .XWRITEO(XWRITEO), .XDO(XDO), .XDOE(XDOE), .XDI(XDI),
    .XDTACK(XDTACK), .XBERR(XBERR)
  );

  initial begin
    CPLDCLK = 1'b0;
    forever #5 CPLDCLK = ~CPLDCLK;
  end

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       err;
    logic [7:0] rdata;
  } exp_t;
  exp_t       sb_q[$];
  exp_t       exp_v;
  logic [7:0] model_rdata;

  // Responder behaviour: 0 = DTACK, 1 = BERR, 2 = silent, 3 = DTACK+BERR
  int         resp_mode  = 0;
  int         resp_delay = 0;
  logic [7:0] resp_data  = 8'h00;
  int         resp_cnt   = 0;

  initial begin
    XDTACK = 1'b1;
    XBERR  = 1'b1;
    XDI    = 8'h00;
    forever begin
      @(posedge CPLDCLK);
      #1;
      if (XDSO[0] == 1'b0) begin
        if (resp_cnt >= resp_delay) begin
          XDI = resp_data;
          if (resp_mode == 0 || resp_mode == 3) XDTACK = 1'b0;
          if (resp_mode == 1 || resp_mode == 3) XBERR  = 1'b0;
        end
        resp_cnt++;
      end else begin
        XDTACK   = 1'b1;
        XBERR    = 1'b1;
        resp_cnt = 0;
      end
    end
  end

  // Issue one request and record what the bus did until DONE (or budget)
  task automatic run_txn(
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [5:0]  amod,
    input  logic [7:0]  wdata,
    input  int          budget,
    output logic        got_done,
    output logic        err,
    output logic [7:0]  rdata,
    output logic        busy_at_done,
    output logic        xaso_at_done,
    output logic        xwr_at1,
    output logic [15:0] xao_at1,
    output logic [5:0]  xamo_at1,
    output int          as_lat,
    output int          ds_lat,
    output int          ds_lo,
    output int          dt_cyc,
    output int          rel_cyc,
    output int          doe_cyc,
    output int          xdo_bad
  );
    @(negedge CPLDCLK);
    REQ = 1'b1; WR = wr; ADDR = addr; AMOD = amod; WDATA = wdata;
    @(posedge CPLDCLK);
    #1;
    REQ = 1'b0; WR = ~wr; ADDR = ~addr; AMOD = ~amod; WDATA = ~wdata;
    got_done = 1'b0; err = 1'bx; rdata = 8'hxx;
    busy_at_done = 1'bx; xaso_at_done = 1'bx;
    xwr_at1 = 1'bx; xao_at1 = 16'hxxxx; xamo_at1 = 6'hxx;
    as_lat = -1; ds_lat = -1; ds_lo = 0; dt_cyc = -1; rel_cyc = -1;
    doe_cyc = 0; xdo_bad = 0;
    for (int c = 1; c <= budget && !got_done; c++) begin
      @(negedge CPLDCLK);
      if (c == 1) begin
        xwr_at1 = XWRITEO; xao_at1 = XAO; xamo_at1 = XAMO;
      end
      if (XASO == 1'b0 && as_lat < 0) as_lat = c;
      if (XDSO[0] == 1'b0) begin
        ds_lo++;
        if (ds_lat < 0) ds_lat = c;
      end else if (ds_lat >= 0 && rel_cyc < 0) begin
        rel_cyc = c;
      end
      if ((XDTACK == 1'b0 || XBERR == 1'b0) && dt_cyc < 0) dt_cyc = c;
      if (XDOE) begin
        doe_cyc++;
        if (XDO !== wdata) xdo_bad++;
      end
      if (DONE) begin
        got_done = 1'b1; err = ERR; rdata = RDATA;
        busy_at_done = BUSY; xaso_at_done = XASO;
      end
    end
  endtask

  logic        t_done, t_err, t_busy, t_xaso, t_xwr;
  logic [7:0]  t_rdata;
  logic [15:0] t_xao;
  logic [5:0]  t_xamo;
  int          t_as, t_ds, t_dslo, t_dt, t_rel, t_doe, t_xdobad;

  task automatic test_reset();
    CRST = 1'b1; REQ = 1'b0; WR = 1'b0; ADDR = 16'h0; AMOD = 6'h0; WDATA = 8'h0;
    repeat (3) @(negedge CPLDCLK);
    CRST = 1'b0;
    model_rdata = 8'h00;
    checks++; if (BUSY !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", BUSY); end
    checks++; if (DONE !== 1'b0)      begin errors++; $display("FAIL reset_done got %b want 0", DONE); end
    checks++; if (ERR !== 1'b0)       begin errors++; $display("FAIL reset_err got %b want 0", ERR); end
    checks++; if (RDATA !== 8'h00)    begin errors++; $display("FAIL reset_rdata got %h want 00", RDATA); end
    checks++; if (XAO !== 16'h0000)   begin errors++; $display("FAIL reset_xao got %h want 0000", XAO); end
    checks++; if (XAMO !== 6'h00)     begin errors++; $display("FAIL reset_xamo got %h want 00", XAMO); end
    checks++; if (XASO !== 1'b1)      begin errors++; $display("FAIL reset_xaso got %b want 1", XASO); end
    checks++; if (XDSO !== 2'b11)     begin errors++; $display("FAIL reset_xdso got %b want 11", XDSO); end
    checks++; if (XWRITEO !== 1'b1)   begin errors++; $display("FAIL reset_xwriteo got %b want 1", XWRITEO); end
    checks++; if (XDO !== 8'h00)      begin errors++; $display("FAIL reset_xdo got %h want 00", XDO); end
    checks++; if (XDOE !== 1'b0)      begin errors++; $display("FAIL reset_xdoe got %b want 0", XDOE); end
  endtask

  task automatic test_write();
    resp_mode = 0; resp_delay = 4; resp_data = 8'hEE;
    sb_q.push_back('{err: 1'b0, rdata: model_rdata});
    run_txn(1'b1, 16'h1793, AM_A16_SUP, 8'hA5, 300, t_done, t_err, t_rdata, t_busy, t_xaso,
            t_xwr, t_xao, t_xamo, t_as, t_ds, t_dslo, t_dt, t_rel, t_doe, t_xdobad);
    exp_v = sb_q.pop_front();
    checks++; if (t_done !== 1'b1)      begin errors++; $display("FAIL wr_done got %b want 1", t_done); end
    checks++; if (t_err !== exp_v.err)  begin errors++; $display("FAIL wr_err got %b want %b", t_err, exp_v.err); end
    checks++; if (t_rdata !== exp_v.rdata) begin errors++; $display("FAIL wr_rdata got %h want %h", t_rdata, exp_v.rdata); end
    checks++; if (t_xaso !== 1'b1)      begin errors++; $display("FAIL wr_xaso_at_done got %b want 1", t_xaso); end
    checks++; if (t_busy !== 1'b0)      begin errors++; $display("FAIL wr_busy_at_done got %b want 0", t_busy); end
    checks++; if (t_xwr !== 1'b0)       begin errors++; $display("FAIL wr_xwriteo_setup got %b want 0", t_xwr); end
    checks++; if (t_xao !== 16'h1793)   begin errors++; $display("FAIL wr_xao got %h want 1793", t_xao); end
    checks++; if (t_xamo !== 6'h2D)     begin errors++; $display("FAIL wr_xamo got %h want 2d", t_xamo); end
    checks++; if (t_as != SETUP_CYC + 1) begin errors++; $display("FAIL wr_as_latency got %0d want %0d", t_as, SETUP_CYC + 1); end
    checks++; if (t_ds != SETUP_CYC + 2) begin errors++; $display("FAIL wr_ds_latency got %0d want %0d", t_ds, SETUP_CYC + 2); end
    checks++; if (t_rel - t_dt != 3)    begin errors++; $display("FAIL wr_dtack_to_release got %0d want 3", t_rel - t_dt); end
    checks++; if (t_doe != t_rel - 1)   begin errors++; $display("FAIL wr_xdoe_cycles got %0d want %0d", t_doe, t_rel - 1); end
    checks++; if (t_xdobad != 0)        begin errors++; $display("FAIL wr_xdo_value bad_cycles %0d want 0", t_xdobad); end
  endtask

  task automatic test_read();
    resp_mode = 0; resp_delay = 0; resp_data = 8'h3C;
    model_rdata = 8'h3C;
    sb_q.push_back('{err: 1'b0, rdata: model_rdata});
    run_txn(1'b0, 16'h1793, AM_A16_USR, 8'h11, 300, t_done, t_err, t_rdata, t_busy, t_xaso,
            t_xwr, t_xao, t_xamo, t_as, t_ds, t_dslo, t_dt, t_rel, t_doe, t_xdobad);
    exp_v = sb_q.pop_front();
    checks++; if (t_done !== 1'b1)      begin errors++; $display("FAIL rd_done got %b want 1", t_done); end
    checks++; if (t_err !== exp_v.err)  begin errors++; $display("FAIL rd_err got %b want %b", t_err, exp_v.err); end
    checks++; if (t_rdata !== exp_v.rdata) begin errors++; $display("FAIL rd_rdata got %h want %h", t_rdata, exp_v.rdata); end
    checks++; if (t_doe != 0)           begin errors++; $display("FAIL rd_xdoe_cycles got %0d want 0", t_doe); end
    checks++; if (t_xwr !== 1'b1)       begin errors++; $display("FAIL rd_xwriteo got %b want 1", t_xwr); end
    checks++; if (t_xamo !== 6'h29)     begin errors++; $display("FAIL rd_xamo got %h want 29", t_xamo); end
    checks++; if (t_rel - t_dt != 3)    begin errors++; $display("FAIL rd_dtack_to_release got %0d want 3", t_rel - t_dt); end
  endtask

  task automatic test_berr();
    for (int m = 0; m < 2; m++) begin
      resp_mode = (m == 0) ? 1 : 3; resp_delay = 2; resp_data = 8'h77;
      sb_q.push_back('{err: 1'b1, rdata: model_rdata});
      run_txn(1'b0, 16'h0042, AM_A16_SUP, 8'h00, 300, t_done, t_err, t_rdata, t_busy, t_xaso,
              t_xwr, t_xao, t_xamo, t_as, t_ds, t_dslo, t_dt, t_rel, t_doe, t_xdobad);
      exp_v = sb_q.pop_front();
      checks++; if (t_done !== 1'b1)     begin errors++; $display("FAIL berr%0d_done got %b want 1", m, t_done); end
      checks++; if (t_err !== exp_v.err) begin errors++; $display("FAIL berr%0d_err got %b want %b", m, t_err, exp_v.err); end
      checks++; if (t_rdata !== exp_v.rdata) begin errors++; $display("FAIL berr%0d_rdata got %h want %h", m, t_rdata, exp_v.rdata); end
    end
  endtask

  task automatic test_timeout();
    int busy_cnt;
    resp_mode = 2; resp_delay = 0; resp_data = 8'h99;
`ifdef VME_MASTER_TIMEOUT_EN
    sb_q.push_back('{err: 1'b1, rdata: model_rdata});
    run_txn(1'b0, 16'h2000, AM_A16_SUP, 8'h00, 300, t_done, t_err, t_rdata, t_busy, t_xaso,
            t_xwr, t_xao, t_xamo, t_as, t_ds, t_dslo, t_dt, t_rel, t_doe, t_xdobad);
    exp_v = sb_q.pop_front();
    checks++; if (t_done !== 1'b1)      begin errors++; $display("FAIL to_done got %b want 1", t_done); end
    checks++; if (t_err !== exp_v.err)  begin errors++; $display("FAIL to_err got %b want %b", t_err, exp_v.err); end
    checks++; if (t_rdata !== exp_v.rdata) begin errors++; $display("FAIL to_rdata got %h want %h", t_rdata, exp_v.rdata); end
    checks++; if (t_dslo != int'(TIMEOUT_CYC)) begin errors++; $display("FAIL to_ds_cycles got %0d want %0d", t_dslo, TIMEOUT_CYC); end
`else
    busy_cnt = 0;
    @(negedge CPLDCLK);
    REQ = 1'b1; WR = 1'b0; ADDR = 16'h2000; AMOD = AM_A16_SUP;
    @(negedge CPLDCLK);
    REQ = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge CPLDCLK);
      if (BUSY === 1'b1 && DONE === 1'b0) busy_cnt++;
    end
    checks++; if (busy_cnt != 1000) begin errors++; $display("FAIL no_timeout_busy got %0d want 1000", busy_cnt); end
    CRST = 1'b1;
    @(negedge CPLDCLK);
    CRST = 1'b0;
    model_rdata = 8'h00;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL no_timeout_recover_busy got %b want 0", BUSY); end
`endif
  endtask

  task automatic test_reset_mid_dstb();
    int waited;
    int done_cnt;
    resp_mode = 2; resp_delay = 0;
    @(negedge CPLDCLK);
    REQ = 1'b1; WR = 1'b1; ADDR = 16'h0101; AMOD = AM_A16_USR; WDATA = 8'h5A;
    @(negedge CPLDCLK);
    REQ = 1'b0;
    waited = 0;
    while (XDSO[0] !== 1'b0 && waited < 50) begin
      @(negedge CPLDCLK);
      waited++;
    end
    checks++; if (XDSO[0] !== 1'b0) begin errors++; $display("FAIL crst_reach_dstb got %b want 0", XDSO[0]); end
    repeat (3) @(negedge CPLDCLK);
    CRST = 1'b1;
    @(negedge CPLDCLK);
    CRST = 1'b0;
    model_rdata = 8'h00;
    checks++; if (XASO !== 1'b1)  begin errors++; $display("FAIL crst_xaso got %b want 1", XASO); end
    checks++; if (XDSO !== 2'b11) begin errors++; $display("FAIL crst_xdso got %b want 11", XDSO); end
    checks++; if (BUSY !== 1'b0)  begin errors++; $display("FAIL crst_busy got %b want 0", BUSY); end
    checks++; if (XDOE !== 1'b0)  begin errors++; $display("FAIL crst_xdoe got %b want 0", XDOE); end
    done_cnt = (DONE === 1'b1) ? 1 : 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CPLDCLK);
      if (DONE === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL crst_no_done got %0d want 0", done_cnt); end
  endtask

  task automatic test_back_to_back();
    int  ndone;
    int  gap;
    int  ngaps;
    logic after_done;
    resp_mode = 0; resp_delay = 0; resp_data = 8'hC3;
    for (int i = 0; i < 3; i++) sb_q.push_back('{err: 1'b0, rdata: model_rdata});
    ndone = 0; gap = 0; ngaps = 0; after_done = 1'b0;
    @(negedge CPLDCLK);
    REQ = 1'b1; WR = 1'b1; ADDR = 16'hBEEF; AMOD = AM_A16_SUP; WDATA = 8'h81;
    for (int c = 0; c < 300 && ndone < 3; c++) begin
      @(negedge CPLDCLK);
      if (after_done) begin
        if (BUSY === 1'b1) begin
          ngaps++;
          checks++; if (gap != 1) begin errors++; $display("FAIL b2b_idle_gap got %0d want 1", gap); end
          after_done = 1'b0;
        end else begin
          gap++;
        end
      end
      if (DONE === 1'b1) begin
        exp_v = sb_q.pop_front();
        ndone++;
        checks++; if (ERR !== exp_v.err) begin errors++; $display("FAIL b2b_err got %b want %b", ERR, exp_v.err); end
        checks++; if (RDATA !== exp_v.rdata) begin errors++; $display("FAIL b2b_rdata got %h want %h", RDATA, exp_v.rdata); end
        after_done = 1'b1;
        gap = 0;
        if (ndone == 3) REQ = 1'b0;
      end
    end
    REQ = 1'b0;
    checks++; if (ndone != 3)       begin errors++; $display("FAIL b2b_done_count got %0d want 3", ndone); end
    checks++; if (ngaps != 2)       begin errors++; $display("FAIL b2b_gap_count got %0d want 2", ngaps); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL b2b_scoreboard_left got %0d want 0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_berr();
    test_timeout();
    test_reset_mid_dstb();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
